// File: rtl/uart_transmit_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling/stop-length constants.
package uart_transmit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_e;

  localparam int OVS = 16;

  // s_tick counts for 1, 1.5 and 2 stop bits at 16x oversampling
  localparam int STOP_1   = 16;
  localparam int STOP_1P5 = 24;
  localparam int STOP_2   = 32;

endpackage

// File: rtl/uart_transmit.sv
// UART transmitter: serialises din LSB-first (start, DBIT data bits, stop) paced by the 16x s_tick.
// state | meaning: IDLE line high, wait tx_start | START low for OVS ticks | DATA shift out bit 0 | STOP high for SB_TICK ticks
module uart_transmit
  import uart_transmit_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = STOP_1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx
);

  localparam logic [4:0] S_LAST    = 5'(OVS - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  uart_state_e state_q, state_d;
  logic [4:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  b_q, b_d;
  logic        tx_q, tx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    tx_d         = 1'b1;
    tx_done_tick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // a tick coinciding with acceptance is deliberately not counted
        if (tx_start) begin
          state_d = ST_START;
          s_d     = '0;
          b_d     = din;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == S_LAST) begin
            state_d = ST_DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {1'b0, b_q[7:1]};
            if (n_q == N_LAST) state_d = ST_STOP;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == STOP_LAST) begin
            state_d      = ST_IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench: two transmitters (8N1 and 7 data / 2 stop) against a tick-counting frame model.
module tb_uart_transmit;

  int checks = 0;
  int errors = 0;

  logic       clk = 1'b0;
  logic       s_tick = 1'b0;
  logic [1:0] rst_v = 2'b11;
  logic [1:0] start_v = 2'b00;
  logic [7:0] din_v [2];
  logic [1:0] done_v, busy_v, tx_v;
  int         done_cnt [2];
  int         busy_cnt [2];
  int         cyc = 0;
  int         tick_div = 1;
  int         phase = 0;
  int         acc_cyc = 0;

  always #5 clk = ~clk;

  task automatic check(string name, int g, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at cyc %0d: actual=%0h required=%0h", name, g, cyc, act, exp);
    end
  endtask

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int DB    = (g == 0) ? 8 : 7;
      localparam int SBT   = (g == 0) ? 16 : 32;
      localparam int TOTAL = 16 + 16 * DB + SBT;

      logic       m_busy = 1'b0;
      int         m_k = 0;
      logic [7:0] m_data = 8'h00;
      logic       m_tx = 1'b1;

      uart_transmit #(.DBIT(DB), .SB_TICK(SBT)) dut (
        .clk         (clk),
        .reset       (rst_v[g]),
        .tx_start    (start_v[g]),
        .s_tick      (s_tick),
        .din         (din_v[g]),
        .tx_done_tick(done_v[g]),
        .tx_busy     (busy_v[g]),
        .tx          (tx_v[g])
      );

      // line level after k counted ticks of a frame
      function automatic logic level(logic busy, int k, logic [7:0] d);
        if (!busy) return 1'b1;
        if (k < 16) return 1'b0;
        if (k < 16 + 16 * DB) return d[(k - 16) / 16];
        return 1'b1;
      endfunction

      always @(posedge clk or posedge rst_v[g]) begin
        if (rst_v[g]) begin
          m_busy <= 1'b0;
          m_k    <= 0;
          m_data <= 8'h00;
          m_tx   <= 1'b1;
        end else begin
          m_tx <= level(m_busy, m_k, m_data);
          if (!m_busy) begin
            if (start_v[g]) begin
              m_busy <= 1'b1;
              m_k    <= 0;
              m_data <= din_v[g];
            end
          end else if (s_tick) begin
            if (m_k == TOTAL - 1) m_busy <= 1'b0;
            else                  m_k    <= m_k + 1;
          end
        end
      end

      always @(negedge clk) begin
        logic exp_done;
        exp_done = m_busy && s_tick && (m_k == TOTAL - 1);
        check("tx", g, 32'(tx_v[g]), 32'(m_tx));
        check("busy", g, 32'(busy_v[g]), 32'(m_busy));
        check("done", g, 32'(done_v[g]), 32'(exp_done));
        if (done_v[g] === 1'b1) done_cnt[g]++;
        if (busy_v[g] === 1'b1) busy_cnt[g]++;
      end
    end
  endgenerate

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      s_tick = (phase == 0);
      phase  = (phase + 1) % tick_div;
      #1;
    end
  endtask

  task automatic pulse(int g, logic [7:0] d);
    din_v[g]   = d;
    start_v[g] = 1'b1;
    acc_cyc    = cyc;
    step(1);
    start_v[g] = 1'b0;
  endtask

  // samples the middle of each bit period; call right after pulse()
  task automatic sample_frame(int g, int nslots, logic [15:0] exp, int bit_clk);
    step(1 + bit_clk / 2);
    for (int i = 0; i < nslots; i++) begin
      check("frame_bit", g, 32'(tx_v[g]), 32'(exp[i]));
      if (i < nslots - 1) step(bit_clk);
    end
  endtask

  task automatic wait_done(int g, int bound, int exp_len);
    int n;
    n = 0;
    while (done_v[g] !== 1'b1 && n < bound) begin
      step(1);
      n++;
    end
    check("done_reached", g, 32'(done_v[g] === 1'b1), 32'd1);
    check("frame_len", g, 32'(cyc - acc_cyc), 32'(exp_len));
  endtask

  initial begin
    int a;
    int dc;
    din_v[0] = 8'h00;
    din_v[1] = 8'h00;
    done_cnt[0] = 0; done_cnt[1] = 0;
    busy_cnt[0] = 0; busy_cnt[1] = 0;
    step(3);
    rst_v = 2'b00;
    step(2);
    check("rst_tx", 0, 32'(tx_v[0]), 32'd1);
    check("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    check("rst_tx", 1, 32'(tx_v[1]), 32'd1);
    check("rst_busy", 1, 32'(busy_v[1]), 32'd0);

    // 0xA5, tick every clk
    busy_cnt[0] = 0;
    pulse(0, 8'hA5);
    check("busy_after_start", 0, 32'(busy_v[0]), 32'd1);
    sample_frame(0, 10, 16'b0000_0011_0100_1010, 16);
    wait_done(0, 400, 160);
    step(2);
    check("busy_len", 0, 32'(busy_cnt[0]), 32'd160);
    check("done_count", 0, 32'(done_cnt[0]), 32'd1);

    // 0x3C, tick every 4th clk, accepted on a tick cycle
    tick_div = 4;
    phase    = 0;
    step(1);
    for (int i = 0; i < 4 && s_tick !== 1'b1; i++) step(1);
    busy_cnt[0] = 0;
    pulse(0, 8'h3C);
    sample_frame(0, 10, 16'b0000_0010_0111_1000, 64);
    wait_done(0, 1000, 640);
    step(2);
    check("busy_len_div4", 0, 32'(busy_cnt[0]), 32'd640);
    tick_div = 1;
    phase    = 0;
    step(3);

    // start during a frame is ignored; din changes do not leak in
    dc = done_cnt[0];
    pulse(0, 8'h81);
    a = acc_cyc;
    step(40);
    pulse(0, 8'hFF);
    acc_cyc = a;
    wait_done(0, 400, 160);
    step(200);
    check("no_second_frame", 0, 32'(done_cnt[0] - dc), 32'd1);
    check("idle_after", 0, 32'(busy_v[0]), 32'd0);

    // back-to-back: start in done cycle ignored, next cycle accepted
    pulse(0, 8'h5A);
    wait_done(0, 400, 160);
    start_v[0] = 1'b1;
    din_v[0]   = 8'h55;
    step(1);
    check("idle_gap_busy", 0, 32'(busy_v[0]), 32'd0);
    acc_cyc = cyc;
    step(1);
    start_v[0] = 1'b0;
    check("b2b_busy", 0, 32'(busy_v[0]), 32'd1);
    step(1);
    check("b2b_start_bit", 0, 32'(tx_v[0]), 32'd0);
    wait_done(0, 400, 160);
    step(3);

    // reset during data bits of 0x00
    pulse(0, 8'h00);
    step(16 * 4);
    check("data_low", 0, 32'(tx_v[0]), 32'd0);
    dc = done_cnt[0];
    rst_v[0] = 1'b1;
    #1;
    check("abort_tx", 0, 32'(tx_v[0]), 32'd1);
    check("abort_busy", 0, 32'(busy_v[0]), 32'd0);
    check("abort_done", 0, 32'(done_v[0]), 32'd0);
    step(2);
    rst_v[0] = 1'b0;
    step(200);
    check("abort_no_done", 0, 32'(done_cnt[0] - dc), 32'd0);
    pulse(0, 8'h55);
    sample_frame(0, 10, 16'b0000_0010_1010_1010, 16);
    wait_done(0, 400, 160);
    step(3);

    // 7 data bits, 2 stop bits
    pulse(1, 8'hC1);
    sample_frame(1, 9, 16'b0000_0001_1000_0010, 16);
    wait_done(1, 400, 160);
    step(3);
    check("done_count7", 1, 32'(done_cnt[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
